// File: rtl/reg_dump_if.sv
// Byte-stream handshake between the register dumper and its sink.
// A byte moves on any cycle where tx_valid and tx_ready are both high.
interface reg_dump_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/reg_dump.sv
// Streams registers FIRST_REG..LAST_REG out as little-endian byte records.
// Define REG_DUMP_INDEX_EN to prefix each record with its register index.
module reg_dump #(
    parameter int unsigned FIRST_REG = 0,
    parameter int unsigned LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [4:0]  rf_addr,
    input  logic [31:0] rf_data,
    reg_dump_if.master  tx,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        DONE
    } state_t;

    localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
    localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

`ifdef REG_DUMP_INDEX_EN
    localparam logic [2:0] LAST_BYTE = 3'd4;
`else
    localparam logic [2:0] LAST_BYTE = 3'd3;
`endif

    state_t      state;
    state_t      state_n;
    logic [4:0]  idx;
    logic [2:0]  bcnt;
    logic [31:0] snap;
    logic [7:0]  cur_byte;
    logic        xfer;
    logic        last_byte;

    assign xfer      = tx.tx_valid && tx.tx_ready;
    assign last_byte = (bcnt == LAST_BYTE);

    always_comb begin
        cur_byte = 8'h00;
`ifdef REG_DUMP_INDEX_EN
        unique case (bcnt)
            3'd0:    cur_byte = {3'b000, idx};
            3'd1:    cur_byte = snap[7:0];
            3'd2:    cur_byte = snap[15:8];
            3'd3:    cur_byte = snap[23:16];
            3'd4:    cur_byte = snap[31:24];
            default: cur_byte = 8'h00;
        endcase
`else
        unique case (bcnt)
            3'd0:    cur_byte = snap[7:0];
            3'd1:    cur_byte = snap[15:8];
            3'd2:    cur_byte = snap[23:16];
            3'd3:    cur_byte = snap[31:24];
            default: cur_byte = 8'h00;
        endcase
`endif
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (start) state_n = LOAD;
            LOAD: state_n = SEND;
            SEND: begin
                if (xfer && last_byte)
                    state_n = (idx == LAST_IDX) ? DONE : LOAD;
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Snapshot decouples the stream from later register-file writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx  <= FIRST_IDX;
            bcnt <= 3'd0;
            snap <= 32'h0;
        end else begin
            unique case (state)
                IDLE: if (start) idx <= FIRST_IDX;
                LOAD: begin
                    snap <= rf_data;
                    bcnt <= 3'd0;
                end
                SEND: begin
                    if (xfer) begin
                        if (last_byte) begin
                            bcnt <= 3'd0;
                            if (idx != LAST_IDX) idx <= idx + 5'd1;
                        end else begin
                            bcnt <= bcnt + 3'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign rf_addr     = (state == IDLE) ? FIRST_IDX : idx;
    assign tx.tx_valid = (state == SEND);
    assign tx.tx_data  = (state == SEND) ? cur_byte : 8'h00;
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);

endmodule

// File: tb/tb_reg_dump.sv
// Directed bench for reg_dump: full dumps, stalls, snapshot, abort, restart.
// A second instance covers the single-register configuration.
module tb_reg_dump;

`ifdef REG_DUMP_INDEX_EN
    localparam int RB = 5;
`else
    localparam int RB = 4;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        start2;
    logic [4:0]  rf_addr;
    logic [4:0]  rf_addr2;
    logic [31:0] rf_data;
    logic [31:0] rf_data2;
    logic        busy, done, busy2, done2;
    logic [31:0] rf [32];

    logic stall_en = 1'b0;
    logic wr_en    = 1'b0;

    int tests = 0;
    int fails = 0;
    int dcount = 0;
    int d2count = 0;

    logic [7:0] q[$];
    logic [7:0] q2[$];
    logic [7:0] exp_q[$];

    logic       prev_v = 1'b0;
    logic       prev_r = 1'b0;
    logic       prev_rst = 1'b1;
    logic [7:0] prev_d = 8'h00;

    reg_dump_if bus ();
    reg_dump_if bus2 ();

    always #5 clk = ~clk;

    assign rf_data       = rf[rf_addr];
    assign rf_data2      = rf[rf_addr2];
    assign bus2.tx_ready = 1'b1;

    reg_dump dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .rf_addr (rf_addr),
        .rf_data (rf_data),
        .tx      (bus.master),
        .busy    (busy),
        .done    (done)
    );

    reg_dump #(.FIRST_REG(29), .LAST_REG(29)) dut2 (
        .clk     (clk),
        .reset   (reset),
        .start   (start2),
        .rf_addr (rf_addr2),
        .rf_data (rf_data2),
        .tx      (bus2.master),
        .busy    (busy2),
        .done    (done2)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        bus.tx_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (prev_v && !prev_r && !prev_rst) begin
            check("stall_valid", 32'(bus.tx_valid), 32'd1);
            check("stall_data", 32'(bus.tx_data), 32'(prev_d));
        end
        if (!reset && bus.tx_valid && bus.tx_ready) q.push_back(bus.tx_data);
        if (!reset && bus2.tx_valid && bus2.tx_ready)
            q2.push_back(bus2.tx_data);
        if (!reset && done) dcount++;
        if (!reset && done2) d2count++;
        if (wr_en && bus.tx_valid && rf_addr == 5'd3) rf[3] = 32'hFFFF_FFFF;
        prev_v   = bus.tx_valid;
        prev_r   = bus.tx_ready;
        prev_d   = bus.tx_data;
        prev_rst = reset;
    end

    task automatic build_exp(input int first, input int last);
        exp_q.delete();
        for (int r = first; r <= last; r++) begin
`ifdef REG_DUMP_INDEX_EN
            exp_q.push_back(8'(r));
`endif
            for (int b = 0; b < 4; b++) exp_q.push_back(rf[r][8*b +: 8]);
        end
    endtask

    task automatic check_seq(input string tag);
        int n;
        check({tag, "_len"}, q.size(), exp_q.size());
        n = (q.size() < exp_q.size()) ? q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s[%0d]", tag, i), 32'(q[i]), 32'(exp_q[i]));
    endtask

    task automatic wait_done(input int limit, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < limit);
        check({tag, "_done_seen"}, 32'(done), 32'd1);
    endtask

    task automatic kick();
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int o;
        reset = 1'b1;
        start = 1'b0;
        start2 = 1'b0;
        for (int i = 0; i < 32; i++)
            rf[i] = (i == 0) ? 32'h0 : 32'h1000_0000 + 32'(i);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(bus.tx_valid), 32'd0);
        check("rst_data", 32'(bus.tx_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_addr", 32'(rf_addr), 32'd0);
        check("rst_addr2", 32'(rf_addr2), 32'd29);
        @(posedge clk); #2 reset = 1'b0;

        // Plain dump, latency and record layout
        build_exp(0, 31);
        q.delete();
        dcount = 0;
        kick();
        @(negedge clk);
        check("lat_load_busy", 32'(busy), 32'd1);
        check("lat_load_valid", 32'(bus.tx_valid), 32'd0);
        check("lat_load_addr", 32'(rf_addr), 32'd0);
        @(negedge clk);
        check("lat_send_valid", 32'(bus.tx_valid), 32'd1);
        check("lat_send_data", 32'(bus.tx_data), 32'd0);
        wait_done(400, "t1");
        check("t1_done_busy", 32'(busy), 32'd1);
        check("t1_done_valid", 32'(bus.tx_valid), 32'd0);
        check("t1_done_addr", 32'(rf_addr), 32'd31);
        @(negedge clk);
        check("t1_idle_busy", 32'(busy), 32'd0);
        check("t1_idle_done", 32'(done), 32'd0);
        check_seq("t1_seq");
        o = 5 * RB + RB - 4;
        check("t1_rec5_b0", 32'(q[o]), 32'h05);
        check("t1_rec5_b1", 32'(q[o+1]), 32'h00);
        check("t1_rec5_b2", 32'(q[o+2]), 32'h00);
        check("t1_rec5_b3", 32'(q[o+3]), 32'h10);
        check("t1_dcount", dcount, 1);

        // Stalled sink plus overwrite of rf[3] during its SEND
        rf[3] = 32'h1234_5678;
        build_exp(0, 31);
        q.delete();
        dcount = 0;
        stall_en = 1'b1;
        wr_en = 1'b1;
        kick();
        wait_done(3000, "t2");
        stall_en = 1'b0;
        wr_en = 1'b0;
        repeat (2) @(negedge clk);
        check_seq("t2_seq");
        o = 3 * RB + RB - 4;
        check("t2_rec3_b0", 32'(q[o]), 32'h78);
        check("t2_rec3_b1", 32'(q[o+1]), 32'h56);
        check("t2_rec3_b2", 32'(q[o+2]), 32'h34);
        check("t2_rec3_b3", 32'(q[o+3]), 32'h12);
        check("t2_dcount", dcount, 1);
        rf[3] = 32'h1000_0003;

        // Start held high: back-to-back dumps separated by one IDLE
        build_exp(0, 31);
        q.delete();
        dcount = 0;
        @(posedge clk); #2 start = 1'b1;
        wait_done(600, "t3a");
        @(negedge clk);
        check("t3_gap_busy", 32'(busy), 32'd0);
        check_seq("t3a_seq");
        q.delete();
        @(negedge clk);
        check("t3_reload_busy", 32'(busy), 32'd1);
        check("t3_reload_valid", 32'(bus.tx_valid), 32'd0);
        check("t3_reload_addr", 32'(rf_addr), 32'd0);
        @(posedge clk); #2 start = 1'b0;
        wait_done(600, "t3b");
        repeat (3) @(negedge clk);
        check_seq("t3b_seq");
        check("t3_dcount", dcount, 2);
        check("t3_end_busy", 32'(busy), 32'd0);

        // Abort after the tenth transfer, then restart
        q.delete();
        dcount = 0;
        kick();
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (q.size() < 10 && n < 300);
        check("t4_ten", q.size(), 10);
        @(posedge clk); #2 reset = 1'b1;
        @(posedge clk); #2 reset = 1'b0;
        @(negedge clk);
        check("t4_abort_valid", 32'(bus.tx_valid), 32'd0);
        check("t4_abort_busy", 32'(busy), 32'd0);
        check("t4_abort_addr", 32'(rf_addr), 32'd0);
        repeat (20) @(negedge clk);
        check("t4_no_more", q.size(), 10);
        check("t4_no_done", dcount, 0);
        for (int i = 0; i < 10; i++)
            check($sformatf("t4_pre[%0d]", i), 32'(q[i]), 32'(exp_q[i]));
        q.delete();
        kick();
        @(negedge clk);
        check("t4_restart_addr", 32'(rf_addr), 32'd0);
        wait_done(400, "t4");
        repeat (2) @(negedge clk);
        check_seq("t4_seq");
        check("t4_dcount", dcount, 1);

        // Single-register instance
        rf[29] = 32'hDEAD_BEEF;
        q2.delete();
        d2count = 0;
        @(posedge clk); #2 start2 = 1'b1;
        @(posedge clk); #2 start2 = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done2 && n < 50);
        check("t5_done_seen", 32'(done2), 32'd1);
        check("t5_done_addr", 32'(rf_addr2), 32'd29);
        repeat (3) @(negedge clk);
        check("t5_len", q2.size(), RB);
        o = RB - 4;
`ifdef REG_DUMP_INDEX_EN
        check("t5_idx", 32'(q2[0]), 32'h1D);
`endif
        check("t5_b0", 32'(q2[o]), 32'hEF);
        check("t5_b1", 32'(q2[o+1]), 32'hBE);
        check("t5_b2", 32'(q2[o+2]), 32'hAD);
        check("t5_b3", 32'(q2[o+3]), 32'hDE);
        check("t5_dcount", d2count, 1);
        check("t5_busy", 32'(busy2), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
